// File: rtl/sd_dat_tx_pkg.sv
// sd_dat_tx shared definitions: FSM states, CRC polynomial, idle line level.
// Optional 1-bit bus mode is enabled by defining SD_DAT_TX_BUS1_EN.
package sd_dat_tx_pkg;

   typedef enum logic [2:0] {
      SD_TX_IDLE  = 3'd0,
      SD_TX_START = 3'd1,
      SD_TX_DATA  = 3'd2,
      SD_TX_CRC   = 3'd3,
      SD_TX_END   = 3'd4
   } sd_tx_state_e;

   localparam logic [15:0] SD_CRC16_POLY = 16'h1021;
   localparam logic [3:0]  SD_DAT_IDLE   = 4'hF;

   // Line values for one data cycle: nibble (high first) or a single bit on DAT[0].
   function automatic logic [3:0] dat_bits(input logic [7:0] b, input logic [2:0] ph,
                                           input logic w1);
      logic [3:0] r;
      if (w1) r = {3'b111, b[~ph]};
      else    r = ph[0] ? b[3:0] : b[7:4];
      return r;
   endfunction

endpackage

// File: rtl/sd_dat_tx_if.sv
// Host-side handshake and pad bus of sd_dat_tx.
// bus_width_1 exists only when SD_DAT_TX_BUS1_EN is defined.
interface sd_dat_tx_if #(parameter int unsigned BLK_LEN_W = 12);

   logic                 start;
   logic [BLK_LEN_W-1:0] blk_len;
   logic [7:0]           data_in;
   logic                 data_valid;
   logic                 data_ready;
   logic [3:0]           DAT_dout;
   logic                 DAT_oe;
   logic                 busy;
   logic                 done;
   logic                 underrun;
`ifdef SD_DAT_TX_BUS1_EN
   logic                 bus_width_1;

   modport master (output start, blk_len, data_in, data_valid, bus_width_1,
                   input  data_ready, DAT_dout, DAT_oe, busy, done, underrun);
   modport slave  (input  start, blk_len, data_in, data_valid, bus_width_1,
                   output data_ready, DAT_dout, DAT_oe, busy, done, underrun);
`else
   modport master (output start, blk_len, data_in, data_valid,
                   input  data_ready, DAT_dout, DAT_oe, busy, done, underrun);
   modport slave  (input  start, blk_len, data_in, data_valid,
                   output data_ready, DAT_dout, DAT_oe, busy, done, underrun);
`endif

endinterface

// File: rtl/sd_crc16.sv
// Serial CRC16 (x^16+x^12+x^5+1, init 0) for one DAT line.
module sd_crc16
   import sd_dat_tx_pkg::*;
(
   input  logic        sd_clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        en,
   input  logic        bit_in,
   output logic [15:0] crc
);

   logic fb;

   assign fb = bit_in ^ crc[15];

   // Shift one data bit into the remainder; clear has priority.
   always_ff @(posedge sd_clk or posedge rst) begin
      if (rst)      crc <= '0;
      else if (clr) crc <= '0;
      else if (en)  crc <= {crc[14:0], 1'b0} ^ (fb ? SD_CRC16_POLY : 16'h0000);
   end

endmodule

// File: rtl/sd_dat_tx.sv
// SD DAT-line block transmitter: start bit, data, per-line CRC16, end bit.
// Define SD_DAT_TX_BUS1_EN to add the latched 1-bit bus mode (bus_width_1).
module sd_dat_tx
   import sd_dat_tx_pkg::*;
#(
   parameter int unsigned BLK_LEN_W = 12
)(
   input logic        sd_clk,
   input logic        rst,
   sd_dat_tx_if.slave bus
);

   localparam int unsigned PH_W  = 3;
   localparam int unsigned CNT_W = 4;
   localparam int unsigned LINES = 4;

   sd_tx_state_e         state_q, state_d;
   logic [BLK_LEN_W-1:0] bytes_q, bytes_d;
   logic [PH_W-1:0]      phase_q, phase_d;
   logic [7:0]           byte_q, byte_d;
   logic [CNT_W-1:0]     crc_cnt_q, crc_cnt_d;
   logic [3:0]           dout_q, dout_d;
   logic                 oe_q, oe_d;
   logic                 ready_q, ready_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 underrun_q, underrun_d;
   logic                 crc_clr;
   logic [LINES-1:0]     crc_en;
   logic [LINES-1:0]     crc_bit;
   logic [15:0]          crc_v [LINES];
   logic [PH_W-1:0]      last_ph;
   logic                 starve;

`ifdef SD_DAT_TX_BUS1_EN
   logic w1_q, w1_d;
`else
   logic w1_q;
   assign w1_q = 1'b0;
`endif

   assign last_ph = w1_q ? PH_W'(7) : PH_W'(1);
   assign starve  = ready_q & ~bus.data_valid;

   // One CRC per DAT line, fed with the value about to be driven on that line.
   for (genvar g = 0; g < LINES; g++) begin : g_crc
      sd_crc16 u_crc (
         .sd_clk (sd_clk),
         .rst    (rst),
         .clr    (crc_clr),
         .en     (crc_en[g]),
         .bit_in (crc_bit[g]),
         .crc    (crc_v[g])
      );
   end

   // Next state, then registered outputs derived from the state being entered.
   always_comb begin
      state_d    = state_q;
      bytes_d    = bytes_q;
      phase_d    = phase_q;
      byte_d     = byte_q;
      crc_cnt_d  = crc_cnt_q;
`ifdef SD_DAT_TX_BUS1_EN
      w1_d       = w1_q;
`endif
      dout_d     = SD_DAT_IDLE;
      oe_d       = 1'b0;
      ready_d    = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      underrun_d = 1'b0;
      crc_clr    = 1'b0;
      crc_en     = '0;
      crc_bit    = '0;

      unique case (state_q)
         SD_TX_IDLE: begin
            if (bus.start && (bus.blk_len != '0)) begin
               state_d = SD_TX_START;
               bytes_d = bus.blk_len;
               crc_clr = 1'b1;
`ifdef SD_DAT_TX_BUS1_EN
               w1_d    = bus.bus_width_1;
`endif
            end
         end
         SD_TX_START: begin
            if (starve) begin
               state_d    = SD_TX_IDLE;
               underrun_d = 1'b1;
               crc_clr    = 1'b1;
            end else begin
               state_d = SD_TX_DATA;
               byte_d  = bus.data_in;
               phase_d = '0;
            end
         end
         SD_TX_DATA: begin
            if (starve) begin
               state_d    = SD_TX_IDLE;
               underrun_d = 1'b1;
               crc_clr    = 1'b1;
            end else if (phase_q == last_ph) begin
               if (bytes_q == BLK_LEN_W'(1)) begin
                  state_d   = SD_TX_CRC;
                  crc_cnt_d = '0;
               end else begin
                  bytes_d = bytes_q - BLK_LEN_W'(1);
                  byte_d  = bus.data_in;
                  phase_d = '0;
               end
            end else begin
               phase_d = phase_q + PH_W'(1);
            end
         end
         SD_TX_CRC: begin
            if (crc_cnt_q == '1) state_d = SD_TX_END;
            else                 crc_cnt_d = crc_cnt_q + CNT_W'(1);
         end
         SD_TX_END: begin
            state_d = SD_TX_IDLE;
            done_d  = 1'b1;
            crc_clr = 1'b1;
         end
         default: state_d = SD_TX_IDLE;
      endcase

      oe_d   = (state_d != SD_TX_IDLE);
      busy_d = oe_d;

      unique case (state_d)
         SD_TX_START: begin
            dout_d  = 4'h0;
            ready_d = 1'b1;
         end
         SD_TX_DATA: begin
            dout_d  = dat_bits(byte_d, phase_d, w1_q);
            crc_en  = w1_q ? 4'b0001 : 4'b1111;
            crc_bit = dout_d;
            ready_d = (phase_d == last_ph) && (bytes_d != BLK_LEN_W'(1));
         end
         SD_TX_CRC: begin
            // CRC sent MSB first: bit index is 15 - count.
            for (int i = 0; i < LINES; i++) dout_d[i] = crc_v[i][~crc_cnt_d];
            if (w1_q) dout_d[3:1] = 3'b111;
         end
         default: dout_d = SD_DAT_IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge sd_clk or posedge rst) begin
      if (rst) begin
         state_q    <= SD_TX_IDLE;
         bytes_q    <= '0;
         phase_q    <= '0;
         byte_q     <= '0;
         crc_cnt_q  <= '0;
         dout_q     <= SD_DAT_IDLE;
         oe_q       <= 1'b0;
         ready_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         underrun_q <= 1'b0;
`ifdef SD_DAT_TX_BUS1_EN
         w1_q       <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         bytes_q    <= bytes_d;
         phase_q    <= phase_d;
         byte_q     <= byte_d;
         crc_cnt_q  <= crc_cnt_d;
         dout_q     <= dout_d;
         oe_q       <= oe_d;
         ready_q    <= ready_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         underrun_q <= underrun_d;
`ifdef SD_DAT_TX_BUS1_EN
         w1_q       <= w1_d;
`endif
      end
   end

   assign bus.DAT_dout   = dout_q;
   assign bus.DAT_oe     = oe_q;
   assign bus.data_ready = ready_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.underrun   = underrun_q;

endmodule

// File: tb/tb_sd_dat_tx.sv
// Bench for sd_dat_tx: per-transfer expected cycle sequence built from the
// frame format, compared against the DUT on every cycle. Honors SD_DAT_TX_BUS1_EN.
module tb_sd_dat_tx;
   import sd_dat_tx_pkg::*;

   localparam int unsigned BLK_LEN_W = 12;
   localparam int K_IDLE = 0, K_REQ = 1, K_START = 2, K_DATA = 3,
                  K_CRC = 4, K_END = 5, K_DONE = 6, K_UND = 7;

   typedef struct {
      int         kind;
      logic [3:0] dout;
      logic       oe, rdy, busy, done, und;
      int         bidx;
   } rec_t;

   logic sd_clk = 1'b0;
   logic rst;

   sd_dat_tx_if #(.BLK_LEN_W(BLK_LEN_W)) bus ();
   sd_dat_tx #(.BLK_LEN_W(BLK_LEN_W)) dut (.sd_clk(sd_clk), .rst(rst), .bus(bus));

   always #5 sd_clk = ~sd_clk;

   int          cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;
   rec_t        exp_q[$];
   int          t0 = 0;
   int          done_dt = -1;
   int          done_cnt = 0;
   int          und_cnt = 0;
   logic [15:0] obs_crc [4];
   logic [7:0]  pay [4096];
   bit          rand_start = 1'b1;

   always @(posedge sd_clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", name, got, want);
      end
   endtask

   function automatic rec_t mk(input int kind, input logic [3:0] d, input logic oe,
                               input logic rdy, input logic busy, input logic done,
                               input logic und, input int bidx);
      rec_t r;
      r.kind = kind; r.dout = d; r.oe = oe; r.rdy = rdy; r.busy = busy;
      r.done = done; r.und = und; r.bidx = bidx;
      return r;
   endfunction

   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
      return {c[14:0], 1'b0} ^ ((b ^ c[15]) ? 16'h1021 : 16'h0000);
   endfunction

   // Per-cycle checker: pops one expectation each cycle, idle when nothing queued.
   task automatic compare_loop();
      rec_t        e;
      logic [8:0]  got, want;
      forever begin
         @(negedge sd_clk);
         if (exp_q.size() != 0) e = exp_q.pop_front();
         else                   e = mk(K_IDLE, 4'hF, 0, 0, 0, 0, 0, -1);
         if (e.kind == K_REQ) t0 = cyc;
         if (e.kind == K_START) for (int i = 0; i < 4; i++) obs_crc[i] = '0;
         if (e.kind == K_CRC)
            for (int i = 0; i < 4; i++) obs_crc[i] = {obs_crc[i][14:0], bus.DAT_dout[i]};
         if (bus.done === 1'b1) begin
            done_cnt++;
            done_dt = cyc - t0;
         end
         if (bus.underrun === 1'b1) und_cnt++;
         got  = {bus.DAT_dout, bus.DAT_oe, bus.data_ready, bus.busy, bus.done, bus.underrun};
         want = {e.dout, e.oe, e.rdy, e.busy, e.done, e.und};
         check($sformatf("cycle%0d kind%0d {dout,oe,rdy,busy,done,und}", cyc, e.kind),
               32'(got), 32'(want));
      end
   endtask

   // Builds the expected frame for n bytes of pay[], then drives it cycle by cycle.
   task automatic send(input int n, input bit w1, input int drop, input int rst_at);
      rec_t        L[$];
      logic [15:0] c [4];
      logic [3:0]  d;
      bit          stop, r;
      int          nb;
      for (int i = 0; i < 4; i++) c[i] = '0;
      L.push_back(mk(K_REQ, 4'hF, 0, 0, 0, 0, 0, -1));
      if (n > 0) begin
         L.push_back(mk(K_START, 4'h0, 1, 1, 1, 0, 0, 0));
         stop = (drop == 0);
         nb   = w1 ? 8 : 2;
         for (int k = 0; k < n && !stop; k++) begin
            for (int p = 0; p < nb; p++) begin
               if (w1) begin
                  d    = {3'b111, pay[k][7-p]};
                  c[0] = crc_step(c[0], d[0]);
               end else begin
                  d = (p == 0) ? pay[k][7:4] : pay[k][3:0];
                  for (int i = 0; i < 4; i++) c[i] = crc_step(c[i], d[i]);
               end
               r = (p == nb - 1) && (k != n - 1);
               L.push_back(mk(K_DATA, d, 1, r, 1, 0, 0, r ? k + 1 : -1));
               if (r && (k + 1 == drop)) stop = 1'b1;
            end
         end
         if (stop) L.push_back(mk(K_UND, 4'hF, 0, 0, 0, 0, 1, -1));
         else begin
            for (int j = 0; j < 16; j++) begin
               if (w1) d = {3'b111, c[0][15-j]};
               else    d = {c[3][15-j], c[2][15-j], c[1][15-j], c[0][15-j]};
               L.push_back(mk(K_CRC, d, 1, 0, 1, 0, 0, -1));
            end
            L.push_back(mk(K_END, 4'hF, 1, 0, 1, 0, 0, -1));
            L.push_back(mk(K_DONE, 4'hF, 0, 0, 0, 1, 0, -1));
         end
      end
      for (int j = 0; j < L.size(); j++) begin
         if (j > 0) begin @(posedge sd_clk); #1; end
         if (j == rst_at) begin
            rst = 1'b1; bus.start = 1'b0; bus.data_valid = 1'b0;
            #1;
            check("reset_mid_xfer {dout,oe,busy}", 32'({bus.DAT_dout, bus.DAT_oe, bus.busy}),
                  32'({4'hF, 2'b00}));
            @(posedge sd_clk); #1;
            rst = 1'b0;
            return;
         end
         bus.start   = (L[j].kind == K_REQ);
         bus.blk_len = BLK_LEN_W'(n);
         if (L[j].busy && rand_start && ($urandom_range(3) == 0)) begin
            bus.start   = 1'b1;
            bus.blk_len = BLK_LEN_W'($urandom_range(20));
         end
`ifdef SD_DAT_TX_BUS1_EN
         bus.bus_width_1 = (L[j].kind == K_REQ) ? w1 : 1'($urandom_range(1));
`endif
         if (L[j].rdy) begin
            bus.data_in    = pay[L[j].bidx];
            bus.data_valid = (L[j].bidx != drop);
         end else begin
            bus.data_in    = 8'($urandom);
            bus.data_valid = 1'($urandom_range(1));
         end
         exp_q.push_back(L[j]);
      end
      @(posedge sd_clk); #1;
      bus.start = 1'b0; bus.data_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge sd_clk); #1; end
   endtask

   initial begin
      string       s;
      logic [15:0] m;
      int          dc, uc, n;
      bit          w1;
      rst = 1'b1;
      bus.start = 1'b0; bus.blk_len = '0; bus.data_in = '0; bus.data_valid = 1'b0;
`ifdef SD_DAT_TX_BUS1_EN
      bus.bus_width_1 = 1'b0;
`endif
      repeat (3) @(posedge sd_clk);
      #1;
      check("reset_state {dout,oe,rdy,busy,done,und}",
            32'({bus.DAT_dout, bus.DAT_oe, bus.data_ready, bus.busy, bus.done, bus.underrun}),
            32'({4'hF, 5'b00000}));
      rst = 1'b0;
      fork compare_loop(); join_none
      idle(2);

      // Pin the CRC model against known values.
      s = "123456789"; m = '0;
      for (int i = 0; i < s.len(); i++)
         for (int b = 7; b >= 0; b--) m = crc_step(m, s[i][b]);
      check("model_crc_123456789", 32'(m), 32'h31C3);
      m = '0;
      for (int i = 0; i < 4096; i++) m = crc_step(m, 1'b1);
      check("model_crc_512xFF", 32'(m), 32'h7FA1);

      // 1 byte of 0x00: all-zero frame, done at T+21.
      rand_start = 1'b0;
      pay[0] = 8'h00; dc = done_cnt;
      send(1, 1'b0, -1, -1);
      check("b00_done_time", 32'(done_dt), 32'd21);
      check("b00_done_count", 32'(done_cnt - dc), 32'd1);
      for (int i = 0; i < 4; i++) check($sformatf("b00_crc_line%0d", i), 32'(obs_crc[i]), 32'h0);

      // 1 byte of 0xA5: per-line CRCs of bit pairs 10/01.
      pay[0] = 8'hA5;
      send(1, 1'b0, -1, -1);
      check("bA5_done_time", 32'(done_dt), 32'd21);
      check("bA5_crc_line3", 32'(obs_crc[3]), 32'h2042);
      check("bA5_crc_line2", 32'(obs_crc[2]), 32'h1021);
      check("bA5_crc_line1", 32'(obs_crc[1]), 32'h2042);
      check("bA5_crc_line0", 32'(obs_crc[0]), 32'h1021);

      // Underrun at the second data_ready of a 4-byte block.
      for (int i = 0; i < 4; i++) pay[i] = 8'($urandom);
      dc = done_cnt; uc = und_cnt;
      send(4, 1'b0, 1, -1);
      idle(3);
      check("underrun_count", 32'(und_cnt - uc), 32'd1);
      check("underrun_no_done", 32'(done_cnt - dc), 32'd0);

      // Zero-length request is ignored.
      dc = done_cnt;
      send(0, 1'b0, -1, -1);
      idle(25);
      check("len0_no_done", 32'(done_cnt - dc), 32'd0);

      // Reset during DATA: no done and no underrun.
      for (int i = 0; i < 6; i++) pay[i] = 8'($urandom);
      dc = done_cnt; uc = und_cnt;
      send(6, 1'b0, -1, 5);
      idle(25);
      check("rst_no_done", 32'(done_cnt - dc), 32'd0);
      check("rst_no_underrun", 32'(und_cnt - uc), 32'd0);

      // Randomized blocks, with start pulses while busy and occasional starvation.
      rand_start = 1'b1;
      for (int t = 0; t < 40; t++) begin
         n = $urandom_range(16, 1);
         for (int i = 0; i < n; i++) pay[i] = 8'($urandom);
`ifdef SD_DAT_TX_BUS1_EN
         w1 = 1'($urandom_range(1));
`else
         w1 = 1'b0;
`endif
         dc = done_cnt;
         if ($urandom_range(4) == 0) send(n, w1, $urandom_range(n - 1), -1);
         else begin
            send(n, w1, -1, -1);
            check($sformatf("rand%0d_done_time", t), 32'(done_dt),
                  32'(19 + (w1 ? 8 : 2) * n));
         end
         idle($urandom_range(3));
      end

`ifdef SD_DAT_TX_BUS1_EN
      // 1-bit mode, 512 bytes of 0xFF.
      rand_start = 1'b0;
      for (int i = 0; i < 512; i++) pay[i] = 8'hFF;
      send(512, 1'b1, -1, -1);
      check("bus1_512_crc_dat0", 32'(obs_crc[0]), 32'h7FA1);
      check("bus1_512_done_time", 32'(done_dt), 32'd4115);
`endif

      idle(4);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
